ntt_fwd_sched: RTL



---
 rtl/ntt_fwd_sched_if.sv | 28 ++
 rtl/ntt_fwd_sched.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/ntt_fwd_sched_if.sv
// Handshake and RAM-control bundle between the forward-NTT scheduler and its
// coefficient banks, twiddle ROM and butterfly pipeline.
interface ntt_fwd_sched_if;
   logic       start;
   logic       busy;
   logic       done;
   logic [2:0] layer;
   logic       rd_bank;
   logic [7:0] rd_addr_a;
   logic [7:0] rd_addr_b;
   logic [6:0] zeta_idx;
   logic       wr_en;
   logic       wr_bank;
   logic [7:0] wr_addr_a;
   logic [7:0] wr_addr_b;

   modport master (
      input  start,
      output busy, done, layer, rd_bank, rd_addr_a, rd_addr_b, zeta_idx,
             wr_en, wr_bank, wr_addr_a, wr_addr_b
   );

   modport slave (
      output start,
      input  busy, done, layer, rd_bank, rd_addr_a, rd_addr_b, zeta_idx,
             wr_en, wr_bank, wr_addr_a, wr_addr_b
   );
endinterface

// File: rtl/ntt_fwd_sched.sv
// Forward Kyber NTT scheduler: one butterfly pair per cycle over 7 layers,
// ping-pong banks, write-back delayed to match the butterfly pipeline.
module ntt_fwd_sched #(
   parameter int unsigned BF_LAT = 3
) (
   input  logic            clk,
   input  logic            rst_n,
   ntt_fwd_sched_if.master bus
);

   localparam int unsigned DEPTH = BF_LAT + 1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

   typedef struct packed {
      logic       vld;
      logic       bank;
      logic [7:0] addr_a;
      logic [7:0] addr_b;
   } wb_t;

   state_e     state_q, state_d;
   logic [6:0] i_q, i_d;
   logic [2:0] layer_q, layer_d;
   logic [3:0] drain_q, drain_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       rd_bank_q, rd_bank_d;
   logic [7:0] rd_a_q, rd_a_d;
   logic [7:0] rd_b_q, rd_b_d;
   logic [6:0] zeta_q, zeta_d;
   wb_t        dly_q [DEPTH];
   wb_t        dly_d [DEPTH];

   logic [7:0] len;
   logic [6:0] grp;
   logic [7:0] off;
   logic [7:0] j;

   // NOTE: every signal gets a default before the case so no latch is inferred.
   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      layer_d = layer_q;
      drain_d = drain_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = RUN;
               layer_d = 3'd0;
               i_d     = 7'd0;
            end
         end
         RUN: begin
            if (i_q == 7'd127) begin
               state_d = DRAIN;
               drain_d = 4'd0;
            end else begin
               i_d = i_q + 7'd1;
            end
         end
         DRAIN: begin
            if (drain_q == 4'(BF_LAT)) begin
               if (layer_q == 3'd6) begin
                  state_d = DONE;
               end else begin
                  state_d = RUN;
                  layer_d = layer_q + 3'd1;
                  i_d     = 7'd0;
               end
            end else begin
               drain_d = drain_q + 4'd1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Addresses are derived from the next-state counters so they land in the
   // output registers on the same edge the issue slot begins.
   always_comb begin
      len = 8'd128 >> layer_d;
      grp = i_d >> (3'd7 - layer_d);
      off = {1'b0, i_d} & (len - 8'd1);
      j   = ({1'b0, grp} << (4'd8 - {1'b0, layer_d})) + off;

      busy_d    = (state_d == RUN) || (state_d == DRAIN);
      done_d    = (state_d == DONE);
      rd_bank_d = layer_d[0];
      rd_a_d    = rd_a_q;
      rd_b_d    = rd_b_q;
      zeta_d    = zeta_q;
      if (state_d == RUN) begin
         rd_a_d = j;
         rd_b_d = j + len;
         zeta_d = (7'd1 << layer_d) + grp;
      end

      dly_d[0] = '{vld: (state_q == RUN), bank: ~rd_bank_q,
                   addr_a: rd_a_q, addr_b: rd_b_q};
      for (int k = 1; k < DEPTH; k++) dly_d[k] = dly_q[k-1];
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         i_q       <= '0;
         layer_q   <= '0;
         drain_q   <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         rd_bank_q <= 1'b0;
         rd_a_q    <= '0;
         rd_b_q    <= '0;
         zeta_q    <= '0;
         // NOTE: the delay line is cleared on reset so no stale write escapes.
         for (int k = 0; k < DEPTH; k++) dly_q[k] <= '0;
      end else begin
         state_q   <= state_d;
         i_q       <= i_d;
         layer_q   <= layer_d;
         drain_q   <= drain_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         rd_bank_q <= rd_bank_d;
         rd_a_q    <= rd_a_d;
         rd_b_q    <= rd_b_d;
         zeta_q    <= zeta_d;
         for (int k = 0; k < DEPTH; k++) dly_q[k] <= dly_d[k];
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.layer     = layer_q;
   assign bus.rd_bank   = rd_bank_q;
   assign bus.rd_addr_a = rd_a_q;
   assign bus.rd_addr_b = rd_b_q;
   assign bus.zeta_idx  = zeta_q;
   assign bus.wr_en     = dly_q[BF_LAT].vld;
   assign bus.wr_bank   = dly_q[BF_LAT].bank;
   assign bus.wr_addr_a = dly_q[BF_LAT].addr_a;
   assign bus.wr_addr_b = dly_q[BF_LAT].addr_b;

endmodule
